// File: rtl/mult_seq_pkg.sv
// Shared constants, FSM encodings and partial-product shift helper for mult_seq_ctrl.
package mult_seq_pkg;

  localparam int DIGIT_W = 4;
  localparam int PP_W    = 8;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_DONE = 2'd2;

  // Bit position of the nibble product a[i] * b[j] within the full product.
  function automatic int unsigned pp_shift(input int unsigned i, input int unsigned j);
    return DIGIT_W * (i + j);
  endfunction

endpackage

// File: rtl/mult_seq_ctrl_pp_accum.sv
// Shift-accumulate datapath: acc += pp << shift_amt each enabled cycle; clr zeroes it.
// One-cycle update, no backpressure (driven purely by the controlling FSM).
module pp_accum
  import mult_seq_pkg::*;
#(
  parameter int OPW = 8,
  parameter int SAW = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 add_en,
  input  logic [SAW-1:0]       shift_amt,
  input  logic [PP_W-1:0]      pp,
  output logic [2*OPW-1:0]     acc
);

  localparam int AW = 2 * OPW;

  logic [AW-1:0] pp_ext;

  assign pp_ext = AW'(pp) << shift_amt;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (add_en) begin
      acc <= acc + pp_ext;
    end
  end

endmodule

// File: rtl/mult_seq_ctrl.sv
// OPW x OPW unsigned multiply over an external 4x4 multiplier; result N*N cycles after accept,
// held in DONE until out_ready. MULT_SEQ_EARLY_ZERO_EN skips RUN when an operand is zero.
module mult_seq_ctrl
  import mult_seq_pkg::*;
#(
  parameter int OPW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OPW-1:0]       in_a,
  input  logic [OPW-1:0]       in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*OPW-1:0]     out_p,
  output logic                 busy,
  output logic [DIGIT_W-1:0]   mul_m,
  output logic [DIGIT_W-1:0]   mul_q,
  input  logic [PP_W-1:0]      mul_p
);

  localparam int N   = OPW / DIGIT_W;
  localparam int NN  = N * N;
  localparam int IW  = $clog2(NN);
  localparam int LN  = $clog2(N);
  localparam int SAW = $clog2(2 * OPW);

  state_t               state;
  logic [IW-1:0]        idx;
  logic [LN-1:0]        i_idx;
  logic [IW-LN-1:0]     j_idx;
  logic [OPW-1:0]       a_reg;
  logic [OPW-1:0]       b_reg;
  logic [2*OPW-1:0]     acc;
  logic [SAW-1:0]       shift_amt;
  logic                 run;
  logic                 accept;
  logic                 skip_run;

  assign run    = (state == S_RUN);
  assign accept = (state == S_IDLE) && in_valid;

  // N is a power of two, so idx splits directly into (j, i) nibble indices.
  assign i_idx = idx[LN-1:0];
  assign j_idx = idx[IW-1:LN];

`ifdef MULT_SEQ_EARLY_ZERO_EN
  assign skip_run = (in_a == '0) || (in_b == '0);
`else
  assign skip_run = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= '0;
      a_reg <= '0;
      b_reg <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_reg <= in_a;
            b_reg <= in_b;
            idx   <= '0;
            state <= skip_run ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          idx <= idx + IW'(1);
          if (idx == IW'(NN - 1)) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign mul_m = run ? a_reg[DIGIT_W*i_idx +: DIGIT_W] : '0;
  assign mul_q = run ? b_reg[DIGIT_W*j_idx +: DIGIT_W] : '0;

  assign shift_amt = SAW'(pp_shift(32'(i_idx), 32'(j_idx)));

  pp_accum #(
    .OPW (OPW),
    .SAW (SAW)
  ) u_pp_accum (
    .clk       (clk),
    .rst       (rst),
    .clr       (accept),
    .add_en    (run),
    .shift_amt (shift_amt),
    .pp        (mul_p),
    .acc       (acc)
  );

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign out_p     = out_valid ? acc : '0;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl (OPW=8) with a behavioural 4x4 multiplier on mul_*;
// products are checked by a scoreboard monitor, timing/handshake by the stimulus thread.
module tb_mult_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_p;
  logic        busy;
  logic [3:0]  mul_m;
  logic [3:0]  mul_q;
  logic [7:0]  mul_p;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_q[$];
  logic [3:0]  seq_m[16];
  logic [3:0]  seq_q[16];

`ifdef MULT_SEQ_EARLY_ZERO_EN
  localparam int ZERO_LAT = 0;
`else
  localparam int ZERO_LAT = 4;
`endif

  always #5 clk = ~clk;

  assign mul_p = mul_m * mul_q;

  mult_seq_ctrl #(.OPW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .busy      (busy),
    .mul_m     (mul_m),
    .mul_q     (mul_q),
    .mul_p     (mul_p)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: each handshake pops one expected product.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got 0x%0h with nothing expected at %0t", out_p, $time);
      end else begin
        check("product", 32'(out_p), 32'(exp_q.pop_front()));
      end
    end
  end

  // Latency is counted in rising edges after the accepting edge until out_valid is seen.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                        input int stall, input bit noise, input int exp_lat);
    int lat;
    out_ready = (stall == 0);
    in_a      = a;
    in_b      = b;
    in_valid  = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    in_valid = noise;
    in_a     = ~a;
    in_b     = 8'hFF;
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (lat < 16) begin
        seq_m[lat] = mul_m;
        seq_q[lat] = mul_q;
      end
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    for (int k = 0; k < stall; k++) begin
      check("stall_valid", 32'({out_valid, in_ready, busy}), 32'(3'b101));
      check("stall_p", 32'(out_p), 32'(exp));
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("handoff_idle", 32'({in_ready, out_valid, busy}), 32'(3'b100));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] seq_exp[4];
    seq_exp[0] = 8'hDB;
    seq_exp[1] = 8'h0B;
    seq_exp[2] = 8'hD0;
    seq_exp[3] = 8'h00;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = 8'h00;
    in_b      = 8'h00;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_flags", 32'({in_ready, out_valid, busy}), 32'(3'b100));
    check("reset_out_p", 32'(out_p), 32'h0);
    check("reset_mul", 32'({mul_m, mul_q}), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 13 x 11 with its nibble feed order
    run_op(8'd13, 8'd11, 16'h008F, 0, 1'b0, 4);
    for (int k = 0; k < 4; k++) begin
      check("mul_seq", 32'({seq_m[k], seq_q[k]}), 32'(seq_exp[k]));
    end

    run_op(8'hFF, 8'hFF, 16'hFE01, 0, 1'b0, 4);
    run_op(8'h80, 8'h02, 16'h0100, 0, 1'b0, 4);

    // Consumer stall of 6 cycles
    run_op(8'h3C, 8'hA5, 16'h26AC, 6, 1'b0, 4);

    // Foreign in_valid pulses through RUN and DONE must be ignored
    run_op(8'h21, 8'h13, 16'h0273, 2, 1'b1, 4);

    // Reset on the second RUN cycle, with in_valid also high: reset wins, nothing emitted
    in_a     = 8'h12;
    in_b     = 8'h34;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("run_before_reset", 32'({busy, in_ready}), 32'(2'b10));
    rst      = 1'b1;
    in_valid = 1'b1;
    in_a     = 8'hFF;
    in_b     = 8'hFF;
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    check("midrun_reset_flags", 32'({in_ready, out_valid, busy}), 32'(3'b100));
    check("midrun_reset_p", 32'(out_p), 32'h0);
    check("midrun_reset_mul", 32'({mul_m, mul_q}), 32'h0);
    repeat (6) begin
      @(posedge clk); #1;
    end
    check("no_stale_output", 32'(out_valid), 32'h0);

    run_op(8'd7, 8'd9, 16'h003F, 0, 1'b0, 4);

    // Zero operand
    run_op(8'h00, 8'h5A, 16'h0000, 0, 1'b0, ZERO_LAT);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
Sequencer that computes an OPW x OPW unsigned product using a single shared 4x4 combinational array multiplier.
- Feeds operand nibble pairs to the multiplier one pair per cycle.
- Shift-accumulates each 8-bit partial product into a 2*OPW-bit result.
- Presents the result on a valid/ready output.
- Sits between the top-level pin interface and the existing 4x4 multiplier instance, which stays external and is driven through the mul_* ports.

Parameters:
- OPW, 8, operand width in bits; legal values are 8 or 16 (must be a multiple of 4).
- N (localparam), OPW/4, nibbles per operand; one operation takes N*N multiply cycles.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operands a/b valid.
- in_ready  out  1  block can accept operands.
- in_a  in  OPW  multiplicand.
- in_b  in  OPW  multiplier.
- out_valid  out  1  out_p holds the finished product.
- out_ready  in  1  consumer accepts out_p.
- out_p  out  2*OPW  product.
- busy  out  1  high in RUN or DONE.
- mul_m  out  4  nibble to shared multiplier M input.
- mul_q  out  4  nibble to shared multiplier Q input.
- mul_p  in  8  shared multiplier product, combinational from mul_m/mul_q.

Behaviour:
- Reset state: IDLE, in_ready=1, out_valid=0, busy=0, out_p=0, mul_m=0, mul_q=0, accumulator=0, index=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid=1 at a rising edge: latch in_a/in_b, clear the accumulator, set idx=0, go to RUN.
- RUN (idx from 0 to N*N-1):
  - i = idx mod N, j = idx div N.
  - mul_m = a[4i+3:4i], mul_q = b[4j+3:4j].
  - At each edge: acc += zero-extend(mul_p) << 4*(i+j), then idx++.
  - After the edge with idx = N*N-1, go to DONE.
  - in_ready=0. in_valid is ignored and no operands are captured.
- Latency: out_valid rises exactly N*N cycles after the accepting edge (4 for OPW=8, 16 for OPW=16).
- DONE:
  - out_valid=1, out_p=acc, held stable while out_ready=0.
  - When out_ready=1 at an edge: go to IDLE, out_valid=0.
  - in_ready=0 in DONE; there is no accept in the same cycle as the handoff.
  - Back-to-back throughput is one operation per N*N+2 cycles.
- mul_m/mul_q are 0 outside RUN.
- Arithmetic:
  - Unsigned only.
  - The accumulator is 2*OPW bits and cannot overflow: max (2^OPW-1)^2 fits.
  - Shifts beyond 2*OPW do not occur.
- Edge cases:
  - Zero operands still take the full N*N cycles (unless EARLY_ZERO_EN).
  - in_valid held high continuously: one capture per IDLE visit.
  - rst asserted in any state: next edge forces full reset values; an in-flight operation is discarded and no out_valid pulse is produced.
  - rst together with in_valid: reset wins.

Optional Feature:
- Macro: MULT_SEQ_EARLY_ZERO_EN.
- Defined:
  - In IDLE, if in_valid=1 and (in_a==0 or in_b==0), go directly to DONE with acc=0. out_valid is asserted on the following cycle and RUN is skipped.
  - mul_m/mul_q are not toggled for that operation.
- Undefined:
  - Every operation takes the full N*N RUN cycles regardless of operand values.

Decomposition:
- Package mult_seq_pkg:
  - state enum (IDLE, RUN, DONE).
  - DIGIT_W=4 and PP_W=8.
  - Function returning the shift amount 4*(i+j).
- Sub-module pp_accum:
  - Holds the 2*OPW accumulator, with clear, add-enable and shift-select inputs.
  - Keeps the shift/add datapath separate from the FSM.
- The 4x4 multiplier itself is not instantiated here; the top level wires it to mul_m/mul_q/mul_p.

Test Plan:
All scenarios use OPW=8 with a bench-side 4x4 combinational multiplier attached to mul_*.
1. 13 x 11, out_ready=1 -> out_valid exactly 4 cycles after accept, out_p=0x008F (143); mul_m/mul_q sequence (D,B),(0,B),(D,0),(0,0).
2. 255 x 255 -> out_p=0xFE01; then 0x80 x 0x02 -> 0x0100. Checks max value and carry across nibbles.
3. 0x3C x 0xA5, out_ready held low 6 cycles after out_valid -> out_valid and out_p=0x26AC stable throughout, in_ready=0; IDLE one cycle after out_ready=1.
4. in_valid pulsed with different operands during RUN and DONE -> ignored; the result matches only the first accepted pair.
5. rst=1 on the 2nd RUN cycle -> next cycle state IDLE, in_ready=1, out_valid=0, out_p=0, busy=0; a following 7 x 9 completes with 0x003F.
6. 0 x 0x5A: with MULT_SEQ_EARLY_ZERO_EN, out_valid 1 cycle after accept with out_p=0; without it, 4 cycles with out_p=0.
